// File: rtl/dw_fp_inv_square_pkg.sv
// Shared types and helpers for the sequential inverse-square unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dw_fp_inv_square_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SQ   = 3'd1,
        S_DIV  = 3'd2,
        S_RND  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // status bit positions
    localparam int STAT_ZERO    = 0;
    localparam int STAT_INF     = 1;
    localparam int STAT_INVALID = 2;
    localparam int STAT_TINY    = 3;
    localparam int STAT_HUGE    = 4;
    localparam int STAT_INEXACT = 5;

    // rounding modes; anything above RND_RHA is folded to RND_RNE on capture
    localparam logic [2:0] RND_RNE = 3'd0;
    localparam logic [2:0] RND_RTZ = 3'd1;
    localparam logic [2:0] RND_UP  = 3'd2;
    localparam logic [2:0] RND_DN  = 3'd3;
    localparam logic [2:0] RND_RHA = 3'd4;

    // dividend select codes: value also equals the exponent correction k
    localparam logic [1:0] DVD_1 = 2'd0;
    localparam logic [1:0] DVD_2 = 2'd1;
    localparam logic [1:0] DVD_4 = 2'd2;

    // Round-up decision for a result whose sign is always positive.
    function automatic logic round_inc(input logic [2:0] mode, input logic lsb,
                                       input logic g, input logic r, input logic s);
        logic inc;
        case (mode)
            RND_RTZ, RND_DN: inc = 1'b0;
            RND_UP:          inc = g | r | s;
            RND_RHA:         inc = g;
            default:         inc = g & (lsb | r | s);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/dw_fp_inv_square_div.sv
// Restoring divider: dividend (1, 2 or 4) over P, one quotient bit per cycle, MSB first.
// Latency: n cycles after the start cycle; done is high during the cycle producing the last bit.
// Backpressure: none; the caller must hold off start until the previous division is consumed.
module dw_fp_inv_square_div
    import dw_fp_inv_square_pkg::*;
#(
    parameter int pw = 48,
    parameter int n  = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    dvd_sel,
    input  logic [pw-1:0] divisor,
    output logic [n-1:0]  quot,
    output logic          sticky,
    output logic          done
);

    localparam int CW = $clog2(n);

    // the partial remainder stays below 2*P < 8, so one extra integer bit over P suffices
    logic [pw:0]   rem;
    logic [pw-1:0] dsr;
    logic [CW-1:0] cnt;
    logic          busy;

    logic [pw:0]   dvd_init;
    logic [pw+1:0] diff;
    logic          q_bit;
    logic [pw:0]   rem_sel;
    logic          rem_unused;

    // place the selected dividend in the same fixed point as P (1.0 at bit pw-2)
    always_comb begin
        dvd_init = '0;
        case (dvd_sel)
            DVD_1:   dvd_init[pw-2] = 1'b1;
            DVD_2:   dvd_init[pw-1] = 1'b1;
            default: dvd_init[pw]   = 1'b1;
        endcase
    end

    // trial subtraction for the current quotient bit
    always_comb begin
        diff    = {1'b0, rem} - {2'b00, dsr};
        q_bit   = ~diff[pw+1];
        rem_sel = q_bit ? diff[pw:0] : rem;
    end

    // after a restore the remainder is below P, so its top bit is always clear
    assign rem_unused = rem_sel[pw];

    assign done   = busy && (cnt == CW'(n - 1));
    assign sticky = |rem;

    // iteration state: load on start, shift in one quotient bit per busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            dsr  <= '0;
            quot <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= dvd_init;
            dsr  <= divisor;
            quot <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= {rem_sel[pw-1:0], 1'b0};
            quot <= {quot[n-2:0], q_bit};
            cnt  <= done ? '0 : cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dw_fp_inv_square_seq.sv
// Sequential floating-point inverse square z = 1/(a*a) with squarer, restoring divider and rounding.
// Latency: sig_width+5 edges after accept for normal operands, 1 edge for special operands.
// Backpressure: result held in DONE until out_ready; no new operand accepted until then.
module dw_fp_inv_square_seq
    import dw_fp_inv_square_pkg::*;
#(
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [sig_width+exp_width:0]   a,
    input  logic [2:0]                     rnd,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [sig_width+exp_width:0]   z,
    output logic [7:0]                     status,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int PW   = 2 * (sig_width + 1);
    localparam int N    = sig_width + 3;
    localparam int EZW  = exp_width + 3;
    localparam int BIAS = 2 ** (exp_width - 1) - 1;
    localparam int EMAX = 2 ** exp_width - 1;

    state_t state, state_n;

    // captured operand without its sign, which never affects the result
    logic [sig_width+exp_width-1:0] a_q;
    logic [2:0]                     mode_q;
    logic [EZW-1:0]                 ez_q;

    logic [exp_width-1:0] ea;
    logic [sig_width-1:0] fa;
    logic                 exp_zero, exp_ones, frac_zero, is_special;

    logic [PW-1:0] mant, p;
    logic [1:0]    dvd_sel;
    logic [EZW-1:0] ez_n;
    logic          div_start, div_done, div_sticky;
    logic [N-1:0]  quot;

    logic [sig_width+exp_width:0] spec_z, rnd_z;
    logic [7:0]                   spec_st, rnd_st;

    logic [sig_width-1:0] frac_t, frac_r;
    logic                 g_bit, r_bit, inexact, inc;
    logic [sig_width+1:0] sum;
    logic                 carry;
    logic [EZW-1:0]       ez_r;
    logic                 ovf, unf;
    logic                 sign_unused, misc_unused;

    assign sign_unused = a[sig_width+exp_width];

    // ---------------- classification and squarer ----------------
    assign ea         = a_q[sig_width+exp_width-1:sig_width];
    assign fa         = a_q[sig_width-1:0];
    assign exp_zero   = (ea == '0);
    assign exp_ones   = (ea == '1);
    assign frac_zero  = (fa == '0);
    assign is_special = exp_zero | exp_ones;

    assign mant = {{(sig_width+1){1'b0}}, 1'b1, fa};
    assign p    = mant * mant;

    // P==1 divides 1/P, P<2 divides 2/P, P>=2 divides 4/P so the quotient lands in [1,2)
    always_comb begin
        dvd_sel = DVD_4;
        if (frac_zero) begin
            dvd_sel = DVD_1;
        end else if (!p[PW-1]) begin
            dvd_sel = DVD_2;
        end
    end

    // Ez = 3*bias - 2*ea - k in two's complement; k equals the dividend select code
    assign ez_n = EZW'(3 * BIAS) - {2'b00, ea, 1'b0} - {{(EZW-2){1'b0}}, dvd_sel};

    // special operand results: zero/denormal -> +inf, inf -> +0, NaN -> quiet-ish NaN
    always_comb begin
        spec_z  = '0;
        spec_st = '0;
        if (exp_zero) begin
            spec_z                  = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}};
            spec_st[STAT_INF]       = 1'b1;
        end else if (frac_zero) begin
            spec_st[STAT_ZERO]      = 1'b1;
        end else begin
            spec_z                  = {1'b0, {exp_width{1'b1}}, {(sig_width-1){1'b0}}, 1'b1};
            spec_st[STAT_INVALID]   = 1'b1;
        end
    end

    dw_fp_inv_square_div #(
        .pw (PW),
        .n  (N)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dvd_sel (dvd_sel),
        .divisor (p),
        .quot    (quot),
        .sticky  (div_sticky),
        .done    (div_done)
    );

    // ---------------- rounding and packing ----------------
    assign frac_t  = quot[N-2:2];
    assign g_bit   = quot[1];
    assign r_bit   = quot[0];
    assign inexact = g_bit | r_bit | div_sticky;
    assign inc     = round_inc(mode_q, frac_t[0], g_bit, r_bit, div_sticky);
    assign sum     = {2'b01, frac_t} + {{(sig_width+1){1'b0}}, inc};
    assign carry   = sum[sig_width+1];
    // on carry-out the sum is exactly 2.0, so its fraction field is already zero
    assign frac_r  = sum[sig_width-1:0];
    assign ez_r    = ez_q + {{(EZW-1){1'b0}}, carry};
    assign ovf     = $signed(ez_r) >= $signed(EZW'(EMAX));
    assign unf     = $signed(ez_r) <  $signed(EZW'(1));

    // the quotient integer bit is always 1 and the hidden bit of sum is implied
    assign misc_unused = quot[N-1] ^ sum[sig_width] ^ (^ez_r[EZW-1:exp_width]);

    // final result selection for the normal path, including range limits
    always_comb begin
        rnd_z  = {1'b0, ez_r[exp_width-1:0], frac_r};
        rnd_st = '0;
        rnd_st[STAT_INEXACT] = inexact;
        if (ovf) begin
            rnd_st[STAT_HUGE]    = 1'b1;
            rnd_st[STAT_INEXACT] = 1'b1;
            if (mode_q == RND_RTZ || mode_q == RND_DN) begin
                rnd_z = {1'b0, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
            end else begin
                rnd_z             = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}};
                rnd_st[STAT_INF]  = 1'b1;
            end
        end else if (unf) begin
            rnd_z                = '0;
            rnd_st[STAT_ZERO]    = 1'b1;
            rnd_st[STAT_TINY]    = 1'b1;
            rnd_st[STAT_INEXACT] = 1'b1;
        end
    end

    // ---------------- control FSM ----------------
    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (in_valid)  state_n = S_SQ;
            S_SQ:    state_n = is_special ? S_DONE : S_DIV;
            S_DIV:   if (div_done)  state_n = S_RND;
            S_RND:   state_n = S_DONE;
            S_DONE:  if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // state-decoded outputs and strobes
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        div_start = (state == S_SQ) && !is_special;
    end

    // datapath registers: operand capture, exponent, and result load points
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            mode_q <= RND_RNE;
            ez_q   <= '0;
            z      <= '0;
            status <= '0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                a_q    <= a[sig_width+exp_width-1:0];
                mode_q <= (rnd > RND_RHA) ? RND_RNE : rnd;
            end
            if (state == S_SQ) begin
                ez_q <= ez_n;
                if (is_special) begin
                    z      <= spec_z;
                    status <= spec_st;
                end
            end
            if (state == S_RND) begin
                z      <= rnd_z;
                status <= rnd_st;
            end
        end
    end

endmodule
